bomb_projectile: RTL and testbench

Bomb stage driven by the player block's aim outputs (launch, angle, power) and launch position. It flies a ballistic bomb under gravity over the terrain height map and detonates on ground contact or fuse timeout. It then carves a crater into a registered copy of the terrain and hands the result back for terrain write-back. X/Y/S feed the colour mapper; exploded drives the blast sprite.

---
 rtl/bomb_projectile.sv | 255 +++++++++++++++++++++++++
 tb/tb_bomb_projectile.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bomb_projectile.sv
// bomb_projectile: ballistic bomb stage.
//   Takes the player's aim (launch edge, angle, power, launch position), flies
//   a bomb under gravity across the terrain height map, detonates on ground
//   contact or fuse expiry, carves a crater into a registered copy of the
//   terrain and then holds the blast sprite for a fixed number of frames.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   frame_tick         one-clk pulse per video frame
//   launch             launch request level (rising edge acts, IDLE only)
//   launchX, launchY   launch position in px
//   angle, power       aim: angle 0..8 (9..15 act as 8), power 0..7
//   terrain_data       64 columns x 8-bit height codes, surface Y = 2*h
//   X, Y, S            bomb position and sprite radius (S=0: not drawn)
//   exploded           high while the blast sprite is shown
//   terrain_out        terrain copy with the crater carved in
//   terrain_valid      one-clk pulse when terrain_out holds a new crater
//
// state  | meaning
// IDLE   | no bomb, waiting for a launch edge
// FLIGHT | bomb moving, one physics step per frame_tick
// CARVE  | one crater column per clk, then terrain_valid pulse
// BLAST  | exploded sprite, counts frame_ticks before returning to IDLE
module bomb_projectile #(
  parameter int V_MAX        = 7,
  parameter int GRAV_TICKS   = 6,
  parameter int FUSE_FRAMES  = 180,
  parameter int BOMB_SIZE    = 2,
  parameter int BLAST_RADIUS = 12,
  parameter int BLAST_COLS   = 2,
  parameter int BLAST_DEPTH  = 8,
  parameter int BLAST_FRAMES = 30
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         frame_tick,
  input  logic         launch,
  input  logic [9:0]   launchX,
  input  logic [9:0]   launchY,
  input  logic [3:0]   angle,
  input  logic [2:0]   power,
  input  logic [511:0] terrain_data,
  output logic [9:0]   X,
  output logic [9:0]   Y,
  output logic [9:0]   S,
  output logic         exploded,
  output logic [511:0] terrain_out,
  output logic         terrain_valid
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FLIGHT = 2'd1;
  localparam logic [1:0] ST_CARVE  = 2'd2;
  localparam logic [1:0] ST_BLAST  = 2'd3;

  localparam logic signed [9:0] VMAX_S     = 10'(V_MAX);
  localparam logic [15:0]       GRAV_LAST  = 16'(GRAV_TICKS - 1);
  localparam logic [15:0]       FUSE_LAST  = 16'(FUSE_FRAMES - 1);
  localparam logic [15:0]       BLAST_LAST = 16'(BLAST_FRAMES - 1);
  localparam logic [9:0]        S_BOMB     = 10'(BOMB_SIZE);
  localparam logic [9:0]        S_BLAST    = 10'(BLAST_RADIUS);
  localparam logic [8:0]        DEPTH      = 9'(BLAST_DEPTH);
  localparam logic [7:0]        BCOLS      = 8'(BLAST_COLS);

  logic [1:0]         state;
  logic [9:0]         x_q, y_q, s_q;
  logic signed [9:0]  vx, vy;
  logic [15:0]        grav_cnt, fuse_cnt, blast_cnt;
  logic               launch_q;
  logic               exploded_q, terrain_valid_q;
  logic [511:0]       terrain_q;
  logic [5:0]         carve_col, carve_last;
  logic               carve_done;

  assign X             = x_q;
  assign Y             = y_q;
  assign S             = s_q;
  assign exploded      = exploded_q;
  assign terrain_out   = terrain_q;
  assign terrain_valid = terrain_valid_q;

  // x*205>>11 equals x/10 for the whole visible range 0..639
  function automatic logic [5:0] col_of(input logic [9:0] xp);
    return 6'(({8'd0, xp} * 18'd205) >> 11);
  endfunction

  function automatic logic signed [9:0] clamp_v(input logic signed [9:0] v);
    if (v > VMAX_S)
      return VMAX_S;
    else if (v < -VMAX_S)
      return -VMAX_S;
    return v;
  endfunction

  // launch velocity from the aim table
  logic [3:0]        angle_c;
  logic signed [4:0] dx_sel, dy_sel;
  logic signed [9:0] dx_w, dy_w, pwr_w, prod_x, prod_y;
  logic signed [9:0] vx_launch, vy_launch;

  always_comb begin
    angle_c = (angle > 4'd8) ? 4'd8 : angle;
    dx_sel  = 5'sd0;
    dy_sel  = 5'sd0;
    case (angle_c)
      4'd0:    begin dx_sel = -5'sd4; dy_sel = 5'sd0; end
      4'd1:    begin dx_sel = -5'sd4; dy_sel = 5'sd2; end
      4'd2:    begin dx_sel = -5'sd3; dy_sel = 5'sd3; end
      4'd3:    begin dx_sel = -5'sd2; dy_sel = 5'sd4; end
      4'd4:    begin dx_sel =  5'sd0; dy_sel = 5'sd4; end
      4'd5:    begin dx_sel =  5'sd2; dy_sel = 5'sd4; end
      4'd6:    begin dx_sel =  5'sd3; dy_sel = 5'sd3; end
      4'd7:    begin dx_sel =  5'sd4; dy_sel = 5'sd2; end
      default: begin dx_sel =  5'sd4; dy_sel = 5'sd0; end
    endcase
    dx_w      = {{5{dx_sel[4]}}, dx_sel};
    dy_w      = {{5{dy_sel[4]}}, dy_sel};
    pwr_w     = $signed({7'd0, power} + 10'd1);
    prod_x    = dx_w * pwr_w;
    prod_y    = dy_w * pwr_w;
    vx_launch = clamp_v(prod_x >>> 2);
    vy_launch = clamp_v(-(prod_y >>> 2));
  end

  // one physics step, evaluated with the velocity held before the tick
  logic signed [10:0] nx, ny;
  logic               nx_out, ny_neg, grav_wrap, hit, fuse_out;
  logic signed [9:0]  vy_grav;
  logic [5:0]         nx_col;
  logic [7:0]         h_at;
  logic [7:0]         c_ext, c_hi_sum;
  logic [5:0]         c_lo, c_hi;

  always_comb begin
    nx        = $signed({1'b0, x_q}) + $signed({vx[9], vx});
    ny        = $signed({1'b0, y_q}) + $signed({vy[9], vy});
    nx_out    = nx[10] || (nx > 11'sd639);
    ny_neg    = ny[10];
    grav_wrap = (grav_cnt == GRAV_LAST);
    vy_grav   = clamp_v(grav_wrap ? (vy + 10'sd1) : vy);
    nx_col    = col_of(nx[9:0]);
    h_at      = terrain_data[{nx_col, 3'b000} +: 8];
    hit       = (ny[9:0] >= {1'b0, h_at, 1'b0});
    fuse_out  = (fuse_cnt >= FUSE_LAST);
    c_ext     = {2'b00, nx_col};
    c_hi_sum  = c_ext + BCOLS;
    c_lo      = (c_ext >= BCOLS) ? 6'(c_ext - BCOLS) : 6'd0;
    c_hi      = (c_hi_sum > 8'd63) ? 6'd63 : c_hi_sum[5:0];
  end

  // saturating crater depth for the column being carved
  logic [7:0] h_old, h_new;
  logic [8:0] h_sum;

  always_comb begin
    h_old = terrain_q[{carve_col, 3'b000} +: 8];
    h_sum = {1'b0, h_old} + DEPTH;
    h_new = (h_sum > 9'd239) ? 8'd239 : h_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      x_q             <= '0;
      y_q             <= '0;
      s_q             <= '0;
      vx              <= '0;
      vy              <= '0;
      grav_cnt        <= '0;
      fuse_cnt        <= '0;
      blast_cnt       <= '0;
      launch_q        <= 1'b0;
      exploded_q      <= 1'b0;
      terrain_valid_q <= 1'b0;
      terrain_q       <= '0;
      carve_col       <= '0;
      carve_last      <= '0;
      carve_done      <= 1'b0;
    end else begin
      launch_q        <= launch;
      terrain_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          s_q <= '0;
          if (launch && !launch_q) begin
            state    <= ST_FLIGHT;
            x_q      <= launchX;
            y_q      <= launchY;
            vx       <= vx_launch;
            vy       <= vy_launch;
            grav_cnt <= '0;
            fuse_cnt <= '0;
            s_q      <= S_BOMB;
          end
        end
        ST_FLIGHT: begin
          if (frame_tick) begin
            if (nx_out) begin
              state <= ST_IDLE;
              s_q   <= '0;
            end else begin
              grav_cnt <= grav_wrap ? 16'd0 : 16'(grav_cnt + 16'd1);
              vy       <= vy_grav;
              x_q      <= nx[9:0];
              if (ny_neg) begin
                y_q      <= '0;
                vy       <= '0;
                fuse_cnt <= 16'(fuse_cnt + 16'd1);
              end else begin
                y_q <= ny[9:0];
                if (hit || fuse_out) begin
                  // the copy is taken on the entry edge so columns can start next clk
                  state      <= ST_CARVE;
                  terrain_q  <= terrain_data;
                  carve_col  <= c_lo;
                  carve_last <= c_hi;
                  carve_done <= 1'b0;
                end else begin
                  fuse_cnt <= 16'(fuse_cnt + 16'd1);
                end
              end
            end
          end
        end
        ST_CARVE: begin
          if (!carve_done) begin
            terrain_q[{carve_col, 3'b000} +: 8] <= h_new;
            if (carve_col == carve_last)
              carve_done <= 1'b1;
            else
              carve_col <= carve_col + 6'd1;
          end else begin
            terrain_valid_q <= 1'b1;
            state           <= ST_BLAST;
            exploded_q      <= 1'b1;
            s_q             <= S_BLAST;
            blast_cnt       <= '0;
          end
        end
        default: begin
          if (frame_tick) begin
            if (blast_cnt == BLAST_LAST) begin
              state      <= ST_IDLE;
              exploded_q <= 1'b0;
              s_q        <= '0;
            end else begin
              blast_cnt <= 16'(blast_cnt + 16'd1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bomb_projectile.sv
// tb_bomb_projectile: directed bench for bomb_projectile.
//   dut   : default parameters
//   dut_f : FUSE_FRAMES=4, shares all inputs with dut
module tb_bomb_projectile;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         frame_tick = 1'b0;
  logic         launch = 1'b0;
  logic [9:0]   launchX = '0;
  logic [9:0]   launchY = '0;
  logic [3:0]   angle = '0;
  logic [2:0]   power = '0;
  logic [511:0] terrain_data = '0;

  logic [9:0]   X, Y, S;
  logic         exploded, terrain_valid;
  logic [511:0] terrain_out;

  logic [9:0]   X_f, Y_f, S_f;
  logic         exploded_f, terrain_valid_f;
  logic [511:0] terrain_out_f;

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;
  int valid_cnt_f = 0;

  bomb_projectile dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .launch(launch),
    .launchX(launchX), .launchY(launchY), .angle(angle), .power(power),
    .terrain_data(terrain_data), .X(X), .Y(Y), .S(S), .exploded(exploded),
    .terrain_out(terrain_out), .terrain_valid(terrain_valid)
  );

  bomb_projectile #(.FUSE_FRAMES(4)) dut_f (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .launch(launch),
    .launchX(launchX), .launchY(launchY), .angle(angle), .power(power),
    .terrain_data(terrain_data), .X(X_f), .Y(Y_f), .S(S_f), .exploded(exploded_f),
    .terrain_out(terrain_out_f), .terrain_valid(terrain_valid_f)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (terrain_valid === 1'b1) valid_cnt++;
    if (terrain_valid_f === 1'b1) valid_cnt_f++;
  end

  task automatic pulse();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic tick();
    pulse();
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_flat(input int h);
    for (int i = 0; i < 64; i++) terrain_data[8*i +: 8] = 8'(h);
  endtask

  task automatic do_launch(input int lx, input int ly, input int a, input int p);
    launchX = 10'(lx); launchY = 10'(ly); angle = 4'(a); power = 3'(p);
    @(negedge clk) launch = 1'b1;
    @(negedge clk) launch = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (X !== 10'd0 || Y !== 10'd0 || S !== 10'd0) begin
      errors++; $display("FAIL reset_xys: got X=%0d Y=%0d S=%0d expected 0 0 0", X, Y, S); end
    checks++; if (exploded !== 1'b0 || terrain_valid !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got exploded=%b valid=%b expected 0 0", exploded, terrain_valid); end
    checks++; if (terrain_out !== 512'd0) begin
      errors++; $display("FAIL reset_terrain: got nonzero terrain_out expected 0"); end
  endtask

  task automatic test_flat_arc();
    int base, seen_at, bad, hi;
    set_flat(200);
    base = valid_cnt;
    do_launch(320, 300, 4, 3);
    checks++; if (X !== 10'd320 || Y !== 10'd300 || S !== 10'd2) begin
      errors++; $display("FAIL arc_launch: got X=%0d Y=%0d S=%0d expected 320 300 2", X, Y, S); end
    tick();
    checks++; if (Y !== 10'd296 || X !== 10'd320) begin
      errors++; $display("FAIL arc_tick1: got X=%0d Y=%0d expected 320 296", X, Y); end
    for (int t = 2; t <= 6; t++) tick();
    checks++; if (Y !== 10'd276) begin
      errors++; $display("FAIL arc_tick6: got Y=%0d expected 276", Y); end
    tick();
    checks++; if (Y !== 10'd273) begin
      errors++; $display("FAIL arc_gravity_tick7: got Y=%0d expected 273", Y); end
    for (int t = 8; t <= 70; t++) tick();
    checks++; if (Y !== 10'd394 || S !== 10'd2 || valid_cnt != base) begin
      errors++; $display("FAIL arc_tick70: got Y=%0d S=%0d valids=%0d expected 394 2 0", Y, S, valid_cnt - base); end
    pulse();
    checks++; if (Y !== 10'd401 || X !== 10'd320) begin
      errors++; $display("FAIL arc_impact: got X=%0d Y=%0d expected 320 401", X, Y); end
    seen_at = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (terrain_valid === 1'b1 && seen_at == 0) seen_at = k;
    end
    checks++; if (seen_at != 6 || valid_cnt - base != 1) begin
      errors++; $display("FAIL arc_valid_timing: got clk=%0d pulses=%0d expected 6 1", seen_at, valid_cnt - base); end
    checks++; if (exploded !== 1'b1 || S !== 10'd12) begin
      errors++; $display("FAIL arc_blast_entry: got exploded=%b S=%0d expected 1 12", exploded, S); end
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (terrain_out[8*i +: 8] !== ((i >= 30 && i <= 34) ? 8'd208 : 8'd200)) bad++;
    checks++; if (bad != 0) begin
      errors++; $display("FAIL arc_crater: got %0d wrong columns expected 0", bad); end
    checks++; if (terrain_out[8*29 +: 8] !== 8'd200 || terrain_out[8*35 +: 8] !== 8'd200) begin
      errors++; $display("FAIL arc_crater_edges: got c29=%0d c35=%0d expected 200 200",
                         terrain_out[8*29 +: 8], terrain_out[8*35 +: 8]); end
    hi = 0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (exploded === 1'b1) hi++;
    end
    checks++; if (hi != 29 || exploded !== 1'b0 || S !== 10'd0) begin
      errors++; $display("FAIL arc_blast_len: got high_after=%0d exploded=%b S=%0d expected 29 0 0", hi, exploded, S); end
  endtask

  task automatic test_despawn();
    int base;
    set_flat(239);
    base = valid_cnt;
    do_launch(10, 100, 0, 7);
    tick();
    checks++; if (X !== 10'd3 || Y !== 10'd100) begin
      errors++; $display("FAIL despawn_tick1: got X=%0d Y=%0d expected 3 100", X, Y); end
    tick();
    checks++; if (S !== 10'd0 || exploded !== 1'b0) begin
      errors++; $display("FAIL despawn_tick2: got S=%0d exploded=%b expected 0 0", S, exploded); end
    repeat (10) @(negedge clk);
    checks++; if (valid_cnt != base || exploded !== 1'b0) begin
      errors++; $display("FAIL despawn_quiet: got pulses=%0d exploded=%b expected 0 0", valid_cnt - base, exploded); end
  endtask

  task automatic set_left_hill();
    set_flat(50);
    for (int i = 0; i < 3; i++) terrain_data[8*i +: 8] = 8'd235;
  endtask

  task automatic test_left_edge();
    int seen_at;
    set_left_hill();
    do_launch(5, 480, 4, 0);
    pulse();
    checks++; if (X !== 10'd5 || Y !== 10'd479) begin
      errors++; $display("FAIL left_impact: got X=%0d Y=%0d expected 5 479", X, Y); end
    seen_at = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (terrain_valid === 1'b1 && seen_at == 0) seen_at = k;
    end
    checks++; if (seen_at != 4) begin
      errors++; $display("FAIL left_carve_clks: got valid at clk %0d expected 4", seen_at); end
    checks++; if (terrain_out[7:0] !== 8'd239 || terrain_out[15:8] !== 8'd239 || terrain_out[23:16] !== 8'd239) begin
      errors++; $display("FAIL left_saturate: got %0d %0d %0d expected 239 239 239",
                         terrain_out[7:0], terrain_out[15:8], terrain_out[23:16]); end
    checks++; if (terrain_out[31:24] !== 8'd50) begin
      errors++; $display("FAIL left_col3: got %0d expected 50", terrain_out[31:24]); end
    for (int t = 1; t <= 30; t++) tick();
    checks++; if (exploded !== 1'b0 || S !== 10'd0) begin
      errors++; $display("FAIL left_blast_end: got exploded=%b S=%0d expected 0 0", exploded, S); end
  endtask

  task automatic test_fuse();
    int base, seen_at;
    do_reset();
    set_flat(239);
    base = valid_cnt_f;
    do_launch(100, 50, 8, 0);
    for (int t = 1; t <= 3; t++) tick();
    checks++; if (X_f !== 10'd103 || Y_f !== 10'd50 || S_f !== 10'd2 || valid_cnt_f != base) begin
      errors++; $display("FAIL fuse_tick3: got X=%0d Y=%0d S=%0d pulses=%0d expected 103 50 2 0",
                         X_f, Y_f, S_f, valid_cnt_f - base); end
    pulse();
    checks++; if (X_f !== 10'd104 || exploded_f !== 1'b0) begin
      errors++; $display("FAIL fuse_tick4: got X=%0d exploded=%b expected 104 0", X_f, exploded_f); end
    seen_at = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (terrain_valid_f === 1'b1 && seen_at == 0) seen_at = k;
    end
    checks++; if (seen_at != 6 || exploded_f !== 1'b1) begin
      errors++; $display("FAIL fuse_carve: got valid at clk %0d exploded=%b expected 6 1", seen_at, exploded_f); end
    do_reset();
  endtask

  task automatic test_launch_hold();
    int base;
    set_left_hill();
    base = valid_cnt;
    launchX = 10'd5; launchY = 10'd480; angle = 4'd4; power = 3'd0;
    @(negedge clk) launch = 1'b1;
    for (int t = 1; t <= 10; t++) tick();
    checks++; if (exploded !== 1'b1 || valid_cnt - base != 1) begin
      errors++; $display("FAIL hold_single: got exploded=%b pulses=%0d expected 1 1", exploded, valid_cnt - base); end
    @(negedge clk) launch = 1'b0;
    @(negedge clk) launch = 1'b1;
    for (int t = 1; t <= 21; t++) tick();
    checks++; if (exploded !== 1'b0 || S !== 10'd0) begin
      errors++; $display("FAIL hold_blast_end: got exploded=%b S=%0d expected 0 0", exploded, S); end
    for (int t = 1; t <= 3; t++) tick();
    checks++; if (S !== 10'd0 || valid_cnt - base != 1) begin
      errors++; $display("FAIL hold_no_queue: got S=%0d pulses=%0d expected 0 1", S, valid_cnt - base); end
    launch = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_in_carve();
    int base;
    set_flat(200);
    base = valid_cnt;
    do_launch(320, 410, 4, 0);
    pulse();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (X !== 10'd0 || Y !== 10'd0 || S !== 10'd0 || exploded !== 1'b0 || terrain_valid !== 1'b0) begin
      errors++; $display("FAIL carve_reset_outs: got X=%0d Y=%0d S=%0d exploded=%b valid=%b expected all 0",
                         X, Y, S, exploded, terrain_valid); end
    checks++; if (terrain_out !== 512'd0) begin
      errors++; $display("FAIL carve_reset_terrain: got nonzero terrain_out expected 0"); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (valid_cnt != base || S !== 10'd0) begin
      errors++; $display("FAIL carve_reset_quiet: got pulses=%0d S=%0d expected 0 0", valid_cnt - base, S); end
  endtask

  initial begin
    test_reset();
    test_flat_arc();
    test_despawn();
    test_left_edge();
    test_fuse();
    test_launch_hold();
    test_reset_in_carve();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
